// File: rtl/nsa_pkg.sv
// Shared constants for the nibble-serial adder sequencer.
// States, slice width and counter sizing helper.
package nsa_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int cnt_w(input int nib);
    int w;
    w = $clog2(nib);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
// Group P/G exported for multi-slice variants.
module cla4_slice
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co,
  output logic             pg,
  output logic             gg
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

  assign c[4] = gg | (pg & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock via one CLA slice.
// Define NSA_SUB_EN to enable subtraction through the sub input.
module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int CW  = cnt_w(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             sub_eff;

  logic [NIB_W-1:0] sl_a;
  logic [NIB_W-1:0] sl_b;
  logic [NIB_W-1:0] sl_s;
  logic             sl_co;
  logic             unused_pg;
  logic             unused_gg;

  logic st_idle;
  logic st_run;
  logic st_done;

`ifdef NSA_SUB_EN
  assign sub_eff = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff    = 1'b0;
`endif

  assign st_idle = (state == IDLE);
  assign st_run  = (state == RUN);
  assign st_done = (state == DONE);

  assign in_ready  = st_idle;
  assign out_valid = st_done;
  assign busy      = st_run | st_done;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  assign sl_a = a_q[{cnt, 2'b00} +: NIB_W];
  assign sl_b = b_q[{cnt, 2'b00} +: NIB_W];

  cla4_slice u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co),
    .pg (unused_pg),
    .gg (unused_gg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub_eff ? ~b : b;
            carry <= cin ^ sub_eff;
            cnt   <= '0;
            state <= RUN;
          end
        end
        st_run: begin
          sum_q[{cnt, 2'b00} +: NIB_W] <= sl_s;
          carry <= sl_co;
          cnt   <= cnt + CW'(1);
          // sl_s[3] is the result MSB on the final nibble
          if (cnt == LAST) begin
            cout_q <= sl_co;
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                   && (sl_s[NIB_W-1] != a_q[WIDTH-1]);
            cnt    <= '0;
            state  <= DONE;
          end
        end
        st_done: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands one nibble per clock through a single 4-bit carry-lookahead slice.
- Registers the slice carry-out between nibbles.
- Uses a valid/ready handshake on both input and output.
- Sits between a register-file/ALU front end and the result writeback, trading latency for area on wide adds.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8; NIB = WIDTH/4.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (borrow-in when subtracting)
- sub  in  1  subtract request (used only with NSA_SUB_EN)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  result
- cout  out  1  final carry-out
- ovf  out  1  signed overflow
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, nibble counter=0, carry reg=0. Reset mid-RUN or DONE aborts; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b (b inverted if subtracting), initial carry=cin (~cin if subtracting), counter=0, go RUN.
  - sum/cout/ovf keep their previous values.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle the slice adds nibble[cnt] of A and B' with the carry reg.
  - sum[4*cnt+3:4*cnt] <= slice sum; carry <= slice cout; cnt++.
  - When cnt==NIB-1: cout <= slice cout; ovf <= (A[MSB]==B'[MSB]) && (slice sum[3]!=A[MSB]); go DONE.
- DONE:
  - out_valid=1; sum/cout/ovf stable.
  - Hold while out_ready=0.
  - On out_ready: out_valid<=0, go IDLE; in_ready rises the following cycle (no same-cycle re-accept).
- Latency: out_valid asserts on the NIB-th rising edge after the accepting edge (4 edges for WIDTH=16). Throughput is one operation per NIB+2 cycles.
- Operand inputs are ignored outside the accept cycle. in_valid while busy is not accepted and not lost; the producer holds it.
- Arithmetic is modulo 2^WIDTH; cout is the true carry out of the MSB nibble.

Optional Feature:
- NSA_SUB_EN defined:
  - sub is sampled at accept.
  - sub=1 computes A−B−cin as A+~B+~cin.
  - cout=1 means no borrow; ovf is signed-subtract overflow.
- NSA_SUB_EN undefined: sub is ignored (tie-off permitted); always A+B+cin.

Decomposition:
- Package nsa_pkg holds:
  - NIB_W=4
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - function for counter width clog2(NIB)
- One sub-module, cla4_slice:
  - Purely combinational 4-bit carry-lookahead adder.
  - Inputs: a[3:0], b[3:0], ci. Outputs: s[3:0], co, group P, group G.
  - Instantiated once; group P/G are unused here but exported for later multi-slice variants.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0; out_valid exactly 4 edges after accept.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1; a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → out_valid, sum, cout stay constant; in_ready=0; in_valid stays pending and is accepted the cycle after in_ready returns to 1.
- Assert rst_n=0 on the 2nd RUN cycle → immediately state IDLE, in_ready=1, out_valid=0, sum=0. A fresh add of 0x00FF+0x0001 afterwards gives 0x0100.
- With NSA_SUB_EN: a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
